// File: rtl/arbiter_request_source_2ch.sv
// Two-channel requester front-end for the round-robin arbiter.
// Per-channel FIFOs feed one registered output stage selected by the grant.
module arbiter_request_source_2ch #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    output logic [1:0]       requests,
    input  logic [1:0]       grants,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic             grant_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem    [2][DEPTH];
    logic [AW-1:0]    rd_ptr [2];
    logic [AW-1:0]    wr_ptr [2];
    logic [CW-1:0]    count  [2];

    logic [1:0]       in_valid;
    logic [1:0]       ready;
    logic [WIDTH-1:0] in_data [2];
    logic [1:0]       push;
    logic [1:0]       pop;
    logic             free;
    logic             legal;
    logic             illegal;
    logic             gnt_id;

    assign in_valid   = {in1_valid, in0_valid};
    assign in_data[0] = in0_data;
    assign in_data[1] = in1_data;
    assign in0_ready  = ready[0];
    assign in1_ready  = ready[1];
    assign free       = ~out_valid | out_ready;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ready[i]    = ~rst & (count[i] != CW'(DEPTH));
            requests[i] = (count[i] != '0) & free & ~rst;
            push[i]     = in_valid[i] & ready[i];
        end
    end

    // Requests are already forced low in reset, so any grant then is illegal.
    always_comb begin
        legal  = 1'b0;
        gnt_id = 1'b0;
        unique case (grants)
            2'b01: legal = requests[0];
            2'b10: begin
                legal  = requests[1];
                gnt_id = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal = (grants != 2'b00) & ~legal;
    assign pop     = legal ? grants : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_id      <= 1'b0;
            grant_error <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= in_data[i];
                    wr_ptr[i]         <= wr_ptr[i] + 1'b1;
                end
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
            end
            if (legal) begin
                out_data  <= mem[gnt_id][rd_ptr[gnt_id]];
                out_id    <= gnt_id;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            grant_error <= illegal;
        end
    end

endmodule
